// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, op-code encodings and the
// occupancy encoding used by the result stage skid buffer.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] ALU_AND = 3'd0;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 3'd1;
  localparam logic [ALU_OPW-1:0] ALU_XOR = 3'd2;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'd3;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'd4;
  localparam logic [ALU_OPW-1:0] ALU_SLT = 3'd5;
  localparam logic [ALU_OPW-1:0] ALU_NOR = 3'd6;
  localparam logic [ALU_OPW-1:0] ALU_MOD = 3'd7;

  // Number of entries held in the result stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  function automatic logic occ_can_accept(input occ_t occ);
    return occ != FULL;
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Upstream (ALU result mux) and downstream handshake bundle of the result stage.
// master = producer/consumer side, slave = the result stage itself.
interface alu_result_stage_if #(
  parameter int W   = 32,
  parameter int OPW = 3
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_result;
  logic [OPW-1:0] in_op;

  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_result;
  logic [OPW-1:0] out_op;
  logic           out_zero;
  logic           out_neg;
  logic           out_par;

  modport master (
    output in_valid, in_result, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_par
  );

  modport slave (
    input  in_valid, in_result, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_par
  );

endinterface

// File: rtl/alu_result_stage_flags.sv
// Combinational status flags for one ALU result: zero, sign and even parity.
module alu_flags_32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] result,
  output logic         zero,
  output logic         neg,
  output logic         par
);

  assign zero = ~|result;
  assign neg  = result[W-1];
  assign par  = ^result;

endmodule

// File: rtl/alu_result_stage.sv
// Registered 2-entry skid-buffer output stage for the ALU result; flags are
// derived at capture. Define ALU_PARITY_EN to store and drive per-entry parity.
module alu_result_stage #(
  parameter int W    = 32,
  parameter int OPW  = 3,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_result_stage_if.slave bus,
  output logic [CNTW-1:0] xfer_cnt
);
  import alu_pkg::*;

  typedef struct packed {
    logic [W-1:0]   result;
    logic [OPW-1:0] op;
    logic           zero;
    logic           neg;
  } entry_t;

  localparam entry_t ENTRY_RST = '{result: '0, op: '0, zero: 1'b1, neg: 1'b0};

  occ_t            occ_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  entry_t          main_reg;
  entry_t          skid_reg;
  logic [CNTW-1:0] xfer_cnt_reg;

  logic   cap_zero;
  logic   cap_neg;
  logic   cap_par;
  entry_t cap_entry;
  logic   accept;
  logic   deliver;

  alu_flags_32 #(.W(W)) u_flags (
    .result (bus.in_result),
    .zero   (cap_zero),
    .neg    (cap_neg),
    .par    (cap_par)
  );

  assign cap_entry = '{result: bus.in_result, op: bus.in_op, zero: cap_zero, neg: cap_neg};
  assign accept    = bus.in_valid & in_ready_reg;
  assign deliver   = out_valid_reg & bus.out_ready;

  // The main slot always drives out_*; the skid slot only fills when the
  // main slot is stalled, so in_ready never looks at out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_reg       <= EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      main_reg      <= ENTRY_RST;
      skid_reg      <= ENTRY_RST;
      xfer_cnt_reg  <= '0;
    end else begin
      if (deliver) begin
        xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
      end
      case (occ_reg)
        EMPTY: begin
          if (accept) begin
            main_reg      <= cap_entry;
            out_valid_reg <= 1'b1;
            occ_reg       <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_reg <= cap_entry;
          end else if (accept) begin
            skid_reg     <= cap_entry;
            occ_reg      <= FULL;
            in_ready_reg <= 1'b0;
          end else if (deliver) begin
            out_valid_reg <= 1'b0;
            occ_reg       <= EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_reg     <= skid_reg;
            occ_reg      <= ONE;
            in_ready_reg <= occ_can_accept(ONE);
          end
        end
        default: begin
          occ_reg       <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_PARITY_EN
  logic main_par_reg;
  logic skid_par_reg;

  // Parity follows its entry through the same slot moves as the FSM above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_par_reg <= 1'b0;
      skid_par_reg <= 1'b0;
    end else begin
      case (occ_reg)
        EMPTY: begin
          if (accept) main_par_reg <= cap_par;
        end
        ONE: begin
          if (accept && deliver) main_par_reg <= cap_par;
          else if (accept)       skid_par_reg <= cap_par;
        end
        FULL: begin
          if (deliver) main_par_reg <= skid_par_reg;
        end
        default: begin
          main_par_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_par = main_par_reg;
`else
  logic unused_par;
  assign unused_par  = cap_par;
  assign bus.out_par = 1'b0;
`endif

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_result = main_reg.result;
  assign bus.out_op     = main_reg.op;
  assign bus.out_zero   = main_reg.zero;
  assign bus.out_neg    = main_reg.neg;
  assign xfer_cnt       = xfer_cnt_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted inputs are queued, a monitor
// checks every output cycle against a FIFO/occupancy reference model.
`timescale 1ns/1ps
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int W    = 32;
  localparam int OPW  = 3;
  localparam int CNTW = 16;
`ifdef ALU_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [W-1:0]   result;
    logic [OPW-1:0] op;
  } exp_t;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [CNTW-1:0] xfer_cnt;

  int   checks      = 0;
  int   failures    = 0;
  exp_t exp_q[$];
  bit   acc_now     = 1'b0;
  bit   mon_en      = 1'b0;
  bit   verbose     = 1'b1;
  int   exp_cnt     = 0;
  int   cyc         = 0;
  int   acc_total   = 0;
  int   deliv_total = 0;
  int   deliv_first = -1;
  int   deliv_last  = -1;

  exp_t           front;
  int             occ;
  bit             prev_stall = 1'b0;
  logic [W-1:0]   prev_res;
  logic [OPW-1:0] prev_op;

  alu_result_stage_if #(.W(W), .OPW(OPW)) bus ();

  alu_result_stage #(.W(W), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_par(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    return PAR_EN && ((ones % 2) == 1);
  endfunction

  // Input side: anything handed over with in_valid & in_ready becomes an expected output.
  always @(negedge clk) begin
    acc_now = 1'b0;
    if (rst_n && mon_en && bus.in_valid && bus.in_ready) begin
      exp_q.push_back('{bus.in_result, bus.in_op});
      acc_now = 1'b1;
      acc_total++;
    end
  end

  // Output side: reference occupancy is the number of accepted-but-undelivered results.
  always @(negedge clk) begin
    #2;
    if (rst_n && mon_en) begin
      occ = exp_q.size() - (acc_now ? 1 : 0);
      chk("out_valid", bus.out_valid, occ != 0);
      chk("in_ready", bus.in_ready, occ < 2);
      chk("xfer_cnt", xfer_cnt, exp_cnt % 65536);
      if (prev_stall) begin
        chk("stall_result", bus.out_result, prev_res);
        chk("stall_op", bus.out_op, prev_op);
      end
      if (bus.out_valid && occ > 0) begin
        front = exp_q[0];
        chk("out_result", bus.out_result, front.result);
        chk("out_op", bus.out_op, front.op);
        chk("out_zero", bus.out_zero, front.result == 0);
        chk("out_neg", bus.out_neg, front.result >= 32'h8000_0000);
        chk("out_par", bus.out_par, exp_par(front.result));
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          exp_cnt++;
          deliv_total++;
          if (deliv_first < 0) deliv_first = cyc;
          deliv_last = cyc;
          if (verbose)
            $display("deliver result=%08h op=%0d zero=%0b neg=%0b par=%0b",
                     bus.out_result, bus.out_op, bus.out_zero, bus.out_neg, bus.out_par);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      prev_op    = bus.out_op;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step(input bit v, input logic [W-1:0] r, input logic [OPW-1:0] o, input bit ordy);
    @(posedge clk);
    #1;
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_op     = o;
    bus.out_ready = ordy;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Assert reset mid-cycle; when check_now is set, outputs must clear without waiting for clk.
  task automatic do_reset(input bit check_now);
    @(posedge clk);
    #3;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    if (check_now) begin
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_xfer_cnt", xfer_cnt, 0);
      chk("rst_out_zero", bus.out_zero, 1);
      chk("rst_out_result", bus.out_result, 0);
      chk("rst_out_par", bus.out_par, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int d0;
    int a0;
    bus.in_valid  = 1'b0;
    bus.in_result = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_out_valid", bus.out_valid, 0);
    chk("init_in_ready", bus.in_ready, 1);
    chk("init_out_result", bus.out_result, 0);
    chk("init_out_op", bus.out_op, 0);
    chk("init_out_zero", bus.out_zero, 1);
    chk("init_out_neg", bus.out_neg, 0);
    chk("init_out_par", bus.out_par, 0);
    chk("init_xfer_cnt", xfer_cnt, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single transfer, one-cycle latency.
    step(1'b0, '0, '0, 1'b1);
    step(1'b1, 32'hFFFF_0000, ALU_XOR, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("single_valid", bus.out_valid, 1);
    chk("single_result", bus.out_result, 32'hFFFF_0000);
    chk("single_neg", bus.out_neg, 1);
    chk("single_zero", bus.out_zero, 0);
    step(1'b0, '0, '0, 1'b1);
    chk("single_cnt", xfer_cnt, 1);

    // Backpressure: A and B fill the buffer, C must be ignored.
    d0 = deliv_total;
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, 32'h1, ALU_AND, 1'b0);
    step(1'b1, 32'h0, ALU_OR, 1'b0);
    step(1'b1, 32'h5, ALU_ADD, 1'b0);
    chk("bp_in_ready", bus.in_ready, 0);
    step(1'b1, 32'h5, ALU_ADD, 1'b0);
    chk("bp_hold_result", bus.out_result, 32'h1);
    step(1'b0, '0, '0, 1'b0);
    drain();
    chk("bp_delivered", deliv_total - d0, 2);
    chk("bp_cnt", xfer_cnt, 3);

    // Streaming: 100 back-to-back results, one delivery per cycle.
    d0 = deliv_total;
    deliv_first = -1;
    for (int i = 0; i < 100; i++) step(1'b1, $urandom, 3'($urandom_range(0, 7)), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    drain();
    chk("stream_count", deliv_total - d0, 100);
    chk("stream_span", deliv_last - deliv_first, 99);
    chk("stream_cnt", xfer_cnt, 103);

    // Reset with two entries held.
    step(1'b1, 32'hDEAD_BEEF, ALU_SUB, 1'b0);
    step(1'b1, 32'h8000_0001, ALU_SLT, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    chk("held_in_ready", bus.in_ready, 0);
    chk("held_out_valid", bus.out_valid, 1);
    do_reset(1'b1);

    // Random stall.
    verbose = 1'b0;
    d0 = deliv_total;
    a0 = acc_total;
    for (int i = 0; i < 10000; i++) begin
      logic [W-1:0] r;
      case ($urandom_range(0, 3))
        0:       r = '0;
        1:       r = 32'h8000_0000 | $urandom;
        default: r = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, r, 3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
    end
    step(1'b0, '0, '0, 1'b1);
    drain();
    chk("rand_accounting", deliv_total - d0, acc_total - a0);

    // Counter wrap and parity.
    do_reset(1'b0);
    for (int i = 0; i < 65535; i++) step(1'b1, $urandom, ALU_NOR, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    drain();
    chk("wrap_preload", xfer_cnt, 16'hFFFF);
    step(1'b1, 32'h0000_0007, ALU_MOD, 1'b1);
    step(1'b0, '0, '0, 1'b1);
    chk("par_seven", bus.out_par, PAR_EN);
    step(1'b0, '0, '0, 1'b1);
    chk("wrap_zero", xfer_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
